guess_entry: RTL and testbench

GUESS_ENTRY -- requirements
Module: guess_entry

---
 rtl/guess_entry.sv | 118 +++++++++++
 tb/tb_guess_entry.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_entry.sv
// rtl/guess_entry.sv - Four-digit guess entry buffer with keypad editing and ready/valid hand-off
// Collects BCD keys into a guess, flags rejected keys for one cycle, then offers the guess downstream.
module guess_entry #(
   parameter int ALLOW_DUP = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        digit_valid,
   input  logic [3:0]  digit,
   input  logic        backspace,
   input  logic        clear,
   input  logic        submit,
   input  logic        guess_ready,
   output logic [15:0] guess,
   output logic        guess_valid,
   output logic [2:0]  digit_count,
   output logic        err_pulse,
   output logic [1:0]  err_code,
   output logic [7:0]  attempt_cnt
);

   typedef enum logic [1:0] {ENTRY, FULL, PEND} state_t;

   localparam logic [1:0] ERR_BAD_DIGIT  = 2'd0;
   localparam logic [1:0] ERR_DUP        = 2'd1;
   localparam logic [1:0] ERR_FULL       = 2'd2;
   localparam logic [1:0] ERR_INCOMPLETE = 2'd3;

   state_t     state;
   logic       dup_hit;
   logic [1:0] bs_pos;

   // Position 0 is the first entered digit, held in the top nibble.
   function automatic logic [15:0] put_nibble(input logic [15:0] g, input logic [1:0] pos,
                                              input logic [3:0] val);
      logic [15:0] r;
      r = g;
      case (pos)
         2'd0:    r[15:12] = val;
         2'd1:    r[11:8]  = val;
         2'd2:    r[7:4]   = val;
         default: r[3:0]   = val;
      endcase
      return r;
   endfunction

   // Empty nibbles hold F, which a legal digit can never equal.
   always_comb begin
      dup_hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (guess[4*i +: 4] == digit) dup_hit = 1'b1;
      end
   end

   assign bs_pos = digit_count[1:0] - 2'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ENTRY;
         guess       <= 16'hFFFF;
         guess_valid <= 1'b0;
         digit_count <= 3'd0;
         err_pulse   <= 1'b0;
         err_code    <= ERR_BAD_DIGIT;
         attempt_cnt <= 8'd0;
      end else begin
         err_pulse <= 1'b0;
         case (state)
            PEND: begin
               if (guess_ready) begin
                  state       <= ENTRY;
                  guess       <= 16'hFFFF;
                  guess_valid <= 1'b0;
                  digit_count <= 3'd0;
                  if (attempt_cnt != 8'hFF) attempt_cnt <= attempt_cnt + 8'd1;
               end
            end
            default: begin
               if (clear) begin
                  state       <= ENTRY;
                  guess       <= 16'hFFFF;
                  digit_count <= 3'd0;
               end else if (backspace) begin
                  if (digit_count != 3'd0) begin
                     guess       <= put_nibble(guess, bs_pos, 4'hF);
                     digit_count <= digit_count - 3'd1;
                     state       <= ENTRY;
                  end
               end else if (submit) begin
                  if (state == FULL) begin
                     state       <= PEND;
                     guess_valid <= 1'b1;
                  end else begin
                     err_pulse <= 1'b1;
                     err_code  <= ERR_INCOMPLETE;
                  end
               end else if (digit_valid) begin
                  if (digit > 4'd9) begin
                     err_pulse <= 1'b1;
                     err_code  <= ERR_BAD_DIGIT;
                  end else if (state == FULL) begin
                     err_pulse <= 1'b1;
                     err_code  <= ERR_FULL;
                  end else if (ALLOW_DUP == 0 && dup_hit) begin
                     err_pulse <= 1'b1;
                     err_code  <= ERR_DUP;
                  end else begin
                     guess       <= put_nibble(guess, digit_count[1:0], digit);
                     digit_count <= digit_count + 3'd1;
                     if (digit_count == 3'd3) state <= FULL;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_guess_entry.sv
// tb/tb_guess_entry.sv - Directed scoreboard bench for guess_entry
// Expectations are queued as stimulus is driven and popped against DUT outputs after each edge.
module tb_guess_entry;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        digit_valid = 1'b0;
   logic [3:0]  digit = 4'd0;
   logic        backspace = 1'b0;
   logic        clear = 1'b0;
   logic        submit = 1'b0;
   logic        guess_ready = 1'b0;
   logic [15:0] guess, guess_d;
   logic        guess_valid, guess_valid_d;
   logic [2:0]  digit_count, digit_count_d;
   logic        err_pulse, err_pulse_d;
   logic [1:0]  err_code, err_code_d;
   logic [7:0]  attempt_cnt, attempt_cnt_d;

   int checks = 0;
   int errors = 0;
   string       tag_q[$];
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   guess_entry #(.ALLOW_DUP(0)) dut (
      .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit), .backspace(backspace),
      .clear(clear), .submit(submit), .guess_ready(guess_ready), .guess(guess),
      .guess_valid(guess_valid), .digit_count(digit_count), .err_pulse(err_pulse),
      .err_code(err_code), .attempt_cnt(attempt_cnt)
   );

   guess_entry #(.ALLOW_DUP(1)) dut_dup (
      .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit), .backspace(backspace),
      .clear(clear), .submit(submit), .guess_ready(guess_ready), .guess(guess_d),
      .guess_valid(guess_valid_d), .digit_count(digit_count_d), .err_pulse(err_pulse_d),
      .err_code(err_code_d), .attempt_cnt(attempt_cnt_d)
   );

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic exp(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic got(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_underflow observed %h expected none", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", t, obs, e);
         end
      end
   endtask

   task automatic exp_state(input string tag, input logic [15:0] g, input logic gv,
                            input logic [2:0] c, input logic ep);
      exp({tag, ".guess"}, 32'(g));
      exp({tag, ".valid"}, 32'(gv));
      exp({tag, ".count"}, 32'(c));
      exp({tag, ".err_pulse"}, 32'(ep));
   endtask

   task automatic got_state();
      got(32'(guess));
      got(32'(guess_valid));
      got(32'(digit_count));
      got(32'(err_pulse));
   endtask

   task automatic key(input logic [3:0] d);
      digit = d;
      digit_valid = 1'b1;
      cycle();
      digit_valid = 1'b0;
   endtask

   task automatic keys4(input logic [15:0] k);
      for (int i = 3; i >= 0; i--) key(k[4*i +: 4]);
   endtask

   task automatic press_submit();
      submit = 1'b1;
      cycle();
      submit = 1'b0;
   endtask

   task automatic press_clear();
      clear = 1'b1;
      cycle();
      clear = 1'b0;
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      exp_state("reset", 16'hFFFF, 1'b0, 3'd0, 1'b0);
      exp("reset.code", 32'd0);
      exp("reset.attempt", 32'd0);
      cycle();
      got_state(); got(32'(err_code)); got(32'(attempt_cnt));
      rst = 1'b0;

      // Basic entry and transfer with ready already high
      guess_ready = 1'b1;
      exp_state("enter1234", 16'h1234, 1'b0, 3'd4, 1'b0);
      keys4(16'h1234);
      got_state();
      exp_state("submit_offer", 16'h1234, 1'b1, 3'd4, 1'b0);
      press_submit();
      got_state();
      exp_state("after_xfer", 16'hFFFF, 1'b0, 3'd0, 1'b0);
      exp("after_xfer.attempt", 32'd1);
      cycle();
      got_state(); got(32'(attempt_cnt));

      // Duplicate rejection, and acceptance when duplicates are allowed
      exp_state("key5_first", 16'h5FFF, 1'b0, 3'd1, 1'b0);
      key(4'd5);
      got_state();
      exp_state("dup5", 16'h5FFF, 1'b0, 3'd1, 1'b1);
      exp("dup5.code", 32'd1);
      exp("dup5.allow_dup_guess", 32'h55FF);
      key(4'd5);
      got_state(); got(32'(err_code)); got(32'(guess_d));
      exp("dup5.pulse_one_cycle", 32'd0);
      cycle();
      got(32'(err_pulse));
      press_clear();

      // Bad digit, incomplete submit, full
      exp_state("bad_digit", 16'hFFFF, 1'b0, 3'd0, 1'b1);
      exp("bad_digit.code", 32'd0);
      key(4'hA);
      got_state(); got(32'(err_code));
      key(4'd1); key(4'd2);
      exp_state("incomplete", 16'h12FF, 1'b0, 3'd2, 1'b1);
      exp("incomplete.code", 32'd3);
      press_submit();
      got_state(); got(32'(err_code));
      key(4'd3); key(4'd4);
      exp_state("full_key", 16'h1234, 1'b0, 3'd4, 1'b1);
      exp("full_key.code", 32'd2);
      key(4'd9);
      got_state(); got(32'(err_code));
      exp_state("full_bad_digit", 16'h1234, 1'b0, 3'd4, 1'b1);
      exp("full_bad_digit.code", 32'd0);
      key(4'hF);
      got_state(); got(32'(err_code));
      press_clear();

      // Held offer ignores clear and keys while ready is low
      guess_ready = 1'b0;
      keys4(16'h5678);
      exp_state("pend_offer", 16'h5678, 1'b1, 3'd4, 1'b0);
      press_submit();
      got_state();
      clear = 1'b1; digit_valid = 1'b1; digit = 4'd1;
      for (int i = 0; i < 3; i++) begin
         exp_state($sformatf("pend_hold%0d", i), 16'h5678, 1'b1, 3'd4, 1'b0);
         cycle();
         got_state();
      end
      clear = 1'b0; digit_valid = 1'b0;
      guess_ready = 1'b1;
      exp_state("pend_xfer", 16'hFFFF, 1'b0, 3'd0, 1'b0);
      exp("pend_xfer.attempt", 32'd2);
      cycle();
      got_state(); got(32'(attempt_cnt));

      // Backspace editing and priorities
      exp_state("bs_empty", 16'hFFFF, 1'b0, 3'd0, 1'b0);
      backspace = 1'b1; cycle(); backspace = 1'b0;
      got_state();
      key(4'd1); key(4'd2); key(4'd3);
      exp_state("bs_one", 16'h12FF, 1'b0, 3'd2, 1'b0);
      backspace = 1'b1; cycle(); backspace = 1'b0;
      got_state();
      key(4'd9);
      exp_state("edit1294", 16'h1294, 1'b0, 3'd4, 1'b0);
      key(4'd4);
      got_state();
      exp_state("bs_from_full", 16'h129F, 1'b0, 3'd3, 1'b0);
      backspace = 1'b1; digit_valid = 1'b1; digit = 4'd7; cycle();
      backspace = 1'b0; digit_valid = 1'b0;
      got_state();
      exp_state("refill", 16'h1295, 1'b0, 3'd4, 1'b0);
      key(4'd5);
      got_state();
      exp_state("clear_beats_bs", 16'hFFFF, 1'b0, 3'd0, 1'b0);
      clear = 1'b1; backspace = 1'b1; cycle(); clear = 1'b0; backspace = 1'b0;
      got_state();

      // Reset aborts a pending transfer
      guess_ready = 1'b0;
      keys4(16'h9876);
      exp_state("abort_offer", 16'h9876, 1'b1, 3'd4, 1'b0);
      submit = 1'b1; digit_valid = 1'b1; digit = 4'd1; cycle();
      submit = 1'b0; digit_valid = 1'b0;
      got_state();
      rst = 1'b1; guess_ready = 1'b1;
      exp_state("rst_in_pend", 16'hFFFF, 1'b0, 3'd0, 1'b0);
      exp("rst_in_pend.attempt", 32'd0);
      cycle();
      got_state(); got(32'(attempt_cnt));
      rst = 1'b0;

      // Attempt counter saturation
      for (int n = 1; n <= 256; n++) begin
         keys4(16'h1234);
         press_submit();
         cycle();
         if (n == 255 || n == 256) begin
            exp($sformatf("attempt_after_%0d", n), 32'd255);
            got(32'(attempt_cnt));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL timeout observed no finish expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
